// File: rtl/gemm_pkg.sv
// Shared types and sizing helpers for the systolic GEMM engine.
package gemm_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 32;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} gemm_state_e;

  // Width of the COMPUTE step counter, which runs 0 .. 3n-3.
  function automatic int cnt_w(input int n);
    return (3 * n - 2 > 2) ? $clog2(3 * n - 2) : 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: multiply-accumulate plus east/south operand forwarding.
module systolic_pe
  import gemm_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_signed,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [AW-1:0] o_acc
);

  logic [2*DW-1:0] prod_u, prod_s;
  logic [AW-1:0]   prod;

  // Signed product taken from sign-extended operands; the low 2*DW bits are exact.
  assign prod_u = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
  assign prod_s = {{DW{i_a[DW-1]}}, i_a} * {{DW{i_b[DW-1]}}, i_b};
  assign prod   = i_signed ? {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s}
                           : {{(AW-2*DW){1'b0}}, prod_u};

  // Accumulate while enabled; forwarding regs drain to zero when idle so a new op starts clean.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_acc <= '0;
      o_a   <= '0;
      o_b   <= '0;
    end else begin
      if (i_clr)     o_acc <= '0;
      else if (i_en) o_acc <= o_acc + prod;
      o_a <= i_en ? i_a : '0;
      o_b <= i_en ? i_b : '0;
    end
  end

endmodule

// File: rtl/systolic_gemm_engine.sv
// NxN output-stationary systolic GEMM: FSM, step counter, operand latches, input skew and PE grid.
module systolic_gemm_engine
  import gemm_pkg::*;
#(
  parameter int N  = 7,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [N*N*DW-1:0] i_a,
  input  logic [N*N*DW-1:0] i_b,
  input  logic              i_signed,
  input  logic              i_accumulate,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [N*N*AW-1:0] o_c,
  output logic              o_valid,
  input  logic              i_resultReady
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(3 * N - 3);

  if (N < 2 || AW < 2 * DW + $clog2(N)) begin : g_param_chk
    $error("systolic_gemm_engine: need N >= 2 and AW >= 2*DW + clog2(N)");
  end

  gemm_state_e                     state;
  logic [CW-1:0]                   cnt;
  logic [N-1:0][N-1:0][DW-1:0]     a_q, b_q;
  logic                            sgn_q, accm_q;
  logic                            fire, clr, en;
  logic [N-1:0][DW-1:0]            a_in, b_in;
  logic [N-1:0][N:0][DW-1:0]       a_h;
  logic [N:0][N-1:0][DW-1:0]       b_v;
  logic [N-1:0][N-1:0][AW-1:0]     acc;
  logic [N-1:0][2*DW-1:0]          edge_unused;

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign fire    = i_valid & o_ready;
  assign clr     = (state == LOAD) & ~accm_q;
  assign en      = (state == COMPUTE);
  assign o_c     = acc;

  // Control FSM; the counter is only meaningful during COMPUTE.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:    if (fire) state <= LOAD;
        LOAD:    begin state <= COMPUTE; cnt <= '0; end
        COMPUTE: if (cnt == LAST) state <= DONE; else cnt <= cnt + 1'b1;
        DONE:    if (i_resultReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands and mode are captured only on the accepting handshake.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      accm_q <= 1'b0;
    end else if (fire) begin
      a_q    <= i_a;
      b_q    <= i_b;
      sgn_q  <= i_signed;
      accm_q <= i_accumulate;
    end
  end

  // Skewed injection: step t feeds A[r][t-r] into row r and B[t-c][c] into column c, else zero.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(cnt) == r + k) begin
          a_in[r] = a_q[r][k];
          b_in[r] = b_q[k][r];
        end
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_edge
    assign a_h[r][0]      = a_in[r];
    assign b_v[0][r]      = b_in[r];
    assign edge_unused[r] = {a_h[r][N], b_v[N][r]};
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_clr    (clr),
        .i_en     (en),
        .i_signed (sgn_q),
        .i_a      (a_h[r][c]),
        .i_b      (b_v[r][c]),
        .o_a      (a_h[r][c+1]),
        .o_b      (b_v[r+1][c]),
        .o_acc    (acc[r][c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Directed + seeded-random bench for systolic_gemm_engine against an integer matmul model.
module tb_systolic_gemm_engine;

  parameter int N = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0][N-1:0][7:0]  ma, mb;
  logic [N-1:0][N-1:0][31:0] oc, exp_c;
  logic sgn, accm, vld, rdy, ovld, rres;
  int   nchk = 0, nerr = 0, lat = 0;

  always #5 clk = ~clk;

  systolic_gemm_engine #(.N(N), .DW(8), .AW(32)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(ma), .i_b(mb), .i_signed(sgn),
    .i_accumulate(accm), .i_valid(vld), .o_ready(rdy), .o_c(oc),
    .o_valid(ovld), .i_resultReady(rres)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_c(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), oc[i][j], exp_c[i][j]);
  endtask

  // Reference: C = (acc ? C : 0) + A*B with sign/zero-extended operands, wrapped to 32 bits.
  task automatic model(input bit s, input bit ac);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [31:0] sum;
        sum = ac ? exp_c[i][j] : 32'h0;
        for (int k = 0; k < N; k++) begin
          longint pa, pb;
          pa = s ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
          pb = s ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
          sum += 32'(pa * pb);
        end
        exp_c[i][j] = sum;
      end
  endtask

  // One operation: optional input stall, fire, wait for result, check it, optionally accept.
  task automatic run_op(input string tag, input bit s, input bit ac,
                        input int stall_in, input int stall_out, input bit accept);
    int cyc;
    repeat (stall_in) @(negedge clk);
    sgn = s; accm = ac; vld = 1'b1;
    chk({tag, "_rdy"}, rdy, 1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    vld = 1'b0; sgn = ~s; accm = ~ac;   // mode pins must not matter after the handshake
    model(s, ac);
    while (!ovld && cyc < 200) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    lat = cyc;
    chk({tag, "_ovld"}, ovld, 1);
    chk_c(tag);
    if (accept) begin
      repeat (stall_out) @(negedge clk);
      rres = 1'b1;
      @(negedge clk);
      rres = 1'b0;
      chk({tag, "_rdy_after"}, rdy, 1);
      chk({tag, "_ovld_after"}, ovld, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int seen;
    ma = '0; mb = '0; sgn = 0; accm = 0; vld = 0; rres = 0; exp_c = '0;

    // Reset state
    #12;
    chk("rst_rdy", rdy, 1);
    chk("rst_ovld", ovld, 0);
    chk("rst_c00", oc[0][0], 0);
    chk("rst_cnn", oc[N-1][N-1], 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: identity * B == B, latency 3N
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = 8'(i * N + j + 1);
      end
    run_op("ident", 0, 0, 0, 0, 1);
    chk("ident_lat", lat, 3 * N);
    chk("ident_c12", oc[1][2], 32'(N + 3));

    // 2: ones, then accumulate again
    ma = {N*N{8'd1}}; mb = {N*N{8'd1}};
    run_op("ones", 0, 0, 1, 0, 1);
    chk("ones_val", oc[0][0], 32'(N));
    run_op("ones_acc", 0, 1, 0, 2, 1);
    chk("ones_acc_val", oc[N-1][0], 32'(2 * N));

    // 3: 0xFF * 2, signed then unsigned
    ma = {N*N{8'hFF}}; mb = {N*N{8'd2}};
    run_op("sgn", 1, 0, 0, 0, 1);
    chk("sgn_val", oc[2][1], 32'(-2 * N));
    run_op("uns", 0, 0, 2, 0, 1);
    chk("uns_val", oc[1][3], 32'(510 * N));

    // 4: result backpressure with a stray request in the window
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 8'(i + j); mb[i][j] = 8'(3 * i + 1);
      end
    run_op("bp", 0, 0, 0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 3) begin vld = 1'b1; ma = {N*N{8'd7}}; end
      if (t == 4) vld = 1'b0;
      chk($sformatf("bp_ovld%0d", t), ovld, 1);
      chk($sformatf("bp_rdy%0d", t), rdy, 0);
    end
    chk_c("bp_hold");
    rres = 1'b1;
    @(negedge clk);
    rres = 1'b0;
    chk("bp_rdy_next", rdy, 1);
    seen = 0;
    repeat (3 * N + 2) begin
      @(negedge clk);
      if (ovld) seen++;
    end
    chk("bp_no_queue", seen, 0);
    chk_c("bp_idle");

    // 5: reset in the middle of COMPUTE (step 5)
    ma = {N*N{8'd9}}; mb = {N*N{8'd5}};
    @(negedge clk);
    vld = 1'b1; sgn = 0; accm = 0;
    @(posedge clk);
    @(negedge clk) vld = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ovld", ovld, 0);
    chk("abort_c00", oc[0][0], 0);
    chk("abort_c11", oc[1][1], 0);
    @(negedge clk); rst_n = 1'b1;
    chk("abort_rdy", rdy, 1);
    exp_c = '0;
    ma = {N*N{8'd1}}; mb = {N*N{8'd1}};
    run_op("post_rst", 0, 1, 0, 0, 1);   // accumulating onto a cleared array
    chk("post_rst_val", oc[0][N-1], 32'(N));

    // 6: random accumulate chain with stalls
    for (int op = 0; op < 20; op++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] = 8'($urandom); mb[i][j] = 8'($urandom);
        end
      run_op($sformatf("rnd%0d", op), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
